// File: rtl/fsm_pkg.sv
// fsm_pkg: state enum and defaults shared by the serializer and the sequence detectors
package fsm_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/pattern_serializer_if.sv
// pattern_serializer_if: valid/ready word stream into the serializer
interface pattern_serializer_if import fsm_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master(output in_data, output in_valid, input in_ready);
  modport slave(input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pattern_serializer.sv
// pattern_serializer: word-to-bit serializer with a one-word hold register for gapless streaming
module pattern_serializer import fsm_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  pattern_serializer_if.slave s,
  output logic out,
  output logic out_valid,
  output logic word_done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_d;
  logic [WIDTH-1:0] sh, sh_d, hold, hold_d, shifted;
  logic [CW-1:0] cnt, cnt_d;
  logic hold_full, hold_full_d, accept, last;
  assign s.in_ready = !hold_full;
  assign accept = s.in_valid & s.in_ready;
  assign last = cnt == LAST;
  assign shifted = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
  assign out_valid = state == SHIFT;
  // gate the head bit so detectors see zeros whenever nothing is shifting
  assign out = out_valid & (MSB_FIRST ? sh[WIDTH-1] : sh[0]);
  assign word_done = out_valid & last;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
      hold <= '0;
      hold_full <= 1'b0;
    end else begin
      state <= state_d;
      sh <= sh_d;
      cnt <= cnt_d;
      hold <= hold_d;
      hold_full <= hold_full_d;
    end
  always_comb begin
    state_d = state;
    sh_d = sh;
    cnt_d = cnt;
    hold_d = hold;
    hold_full_d = hold_full;
    if (state == IDLE) begin
      if (accept) begin
        sh_d = s.in_data;
        cnt_d = '0;
        state_d = SHIFT;
      end
    end else if (!last) begin
      sh_d = shifted;
      cnt_d = cnt + CW'(1);
      if (accept) begin
        hold_d = s.in_data;
        hold_full_d = 1'b1;
      end
    end else if (hold_full) begin
      sh_d = hold;
      cnt_d = '0;
      hold_full_d = 1'b0;
    end else if (accept) begin
      sh_d = s.in_data;
      cnt_d = '0;
    end else begin
      state_d = IDLE;
      cnt_d = '0;
    end
  end
endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: MSB- and LSB-first serializers driven in lockstep against a word-queue model
module tb_pattern_serializer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic vld = 1'b0;
  logic [7:0] dat = '0;
  logic out_m, ov_m, wd_m, out_l, ov_l, wd_l;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  int pos = 0;
  always #5 clk = ~clk;
  pattern_serializer_if #(.WIDTH(8)) bm();
  pattern_serializer_if #(.WIDTH(8)) bl();
  assign bm.in_data = dat;
  assign bm.in_valid = vld;
  assign bl.in_data = dat;
  assign bl.in_valid = vld;
  pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .s(bm), .out(out_m), .out_valid(ov_m), .word_done(wd_m));
  pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .s(bl), .out(out_l), .out_valid(ov_l), .word_done(wd_l));
  typedef struct {
    logic v;
    logic [7:0] d;
    logic e_msb;
    logic e_lsb;
    logic e_ov;
    logic e_wd;
    logic e_rdy;
  } vec_t;
  vec_t tbl[10];
  task automatic cmp(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cmpi(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic mbit(input logic [7:0] w, input int p, input bit msb);
    return msb ? w[7-p] : w[p];
  endfunction
  // word-level reference: head of queue is on the line, pos is its bit index
  task automatic check_model();
    logic busy;
    busy = q.size() > 0;
    cmp("msb_out", out_m, busy ? mbit(q[0], pos, 1'b1) : 1'b0);
    cmp("lsb_out", out_l, busy ? mbit(q[0], pos, 1'b0) : 1'b0);
    cmp("msb_valid", ov_m, busy);
    cmp("lsb_valid", ov_l, busy);
    cmp("msb_done", wd_m, busy && pos == 7);
    cmp("lsb_done", wd_l, busy && pos == 7);
    cmp("msb_ready", bm.in_ready, q.size() < 2);
    cmp("lsb_ready", bl.in_ready, q.size() < 2);
  endtask
  task automatic update(output bit acc);
    acc = 1'b0;
    if (!rst) begin
      q.delete();
      pos = 0;
    end else begin
      acc = vld && q.size() < 2;
      if (q.size() > 0) begin
        if (pos == 7) begin
          void'(q.pop_front());
          pos = 0;
        end else pos++;
      end
      if (acc) q.push_back(dat);
    end
  endtask
  task automatic half(input logic v, input logic [7:0] d);
    vld = v;
    dat = d;
    @(negedge clk);
    check_model();
  endtask
  task automatic fin(output bit acc);
    @(posedge clk);
    update(acc);
    #1;
  endtask
  task automatic tick(input logic v, input logic [7:0] d);
    bit a;
    half(v, d);
    fin(a);
  endtask
  initial begin
    bit acc;
    int nov, ones, nwd, idx;
    int acc_edge[3];
    logic [7:0] words[3];
    tbl[0] = '{1'b1, 8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vld = 1'b1;
    dat = 8'hFF;
    #2;
    cmp("rst_out", out_m, 1'b0);
    cmp("rst_valid", ov_m, 1'b0);
    cmp("rst_done", wd_m, 1'b0);
    cmp("rst_ready", bm.in_ready, 1'b1);
    tick(1'b1, 8'hFF);
    tick(1'b0, 8'h00);
    rst = 1'b1;
    tick(1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      vld = tbl[i].v;
      dat = tbl[i].d;
      @(negedge clk);
      cmp("tbl_msb_out", out_m, tbl[i].e_msb);
      cmp("tbl_lsb_out", out_l, tbl[i].e_lsb);
      cmp("tbl_valid", ov_m, tbl[i].e_ov);
      cmp("tbl_done", wd_m, tbl[i].e_wd);
      cmp("tbl_ready", bm.in_ready, tbl[i].e_rdy);
      check_model();
      fin(acc);
    end
    nov = 0;
    ones = 0;
    nwd = 0;
    for (int i = 0; i < 20; i++) begin
      half(i < 2, i == 0 ? 8'hFF : 8'h00);
      if (ov_m) begin
        nov++;
        if (nov <= 8) ones += int'(out_m);
        else ones += int'(!out_m);
      end
      if (wd_m) nwd += (nov == 8 || nov == 16) ? 1 : 100;
      fin(acc);
    end
    cmpi("b2b_valid_cycles", nov, 16);
    cmpi("b2b_bit_pattern", ones, 16);
    cmpi("b2b_word_done", nwd, 2);
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'hF0;
    idx = 0;
    for (int e = 0; e < 40; e++) begin
      if (idx < 3) half(1'b1, words[idx]);
      else half(1'b0, 8'h00);
      fin(acc);
      if (acc && idx < 3) begin
        acc_edge[idx] = e;
        idx++;
      end
    end
    cmpi("bp_accepts", idx, 3);
    cmpi("bp_second_edge", acc_edge[1], 1);
    cmpi("bp_third_edge", acc_edge[2], 9);
    tick(1'b1, 8'hB4);
    tick(1'b1, 8'h3C);
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    cmp("mid_rst_out", out_m, 1'b0);
    cmp("mid_rst_valid", ov_m, 1'b0);
    cmp("mid_rst_lsb_valid", ov_l, 1'b0);
    cmp("mid_rst_done", wd_m, 1'b0);
    cmp("mid_rst_ready", bm.in_ready, 1'b1);
    q.delete();
    pos = 0;
    tick(1'b1, 8'h55);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) tick(1'b0, 8'h00);
    for (int i = 0; i < 40; i++) tick(1'b1, 8'b1011_0101);
    for (int i = 0; i < 2000; i++) tick(($urandom % 4) != 0, 8'($urandom));
    for (int i = 0; i < 20; i++) tick(1'b0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
